csa_resolve_92: RTL and testbench



---
 rtl/csa_pkg.sv | 14 +
 rtl/cpa_limb.sv | 14 +
 rtl/csa_resolve_92.sv | 104 ++++++++++
 tb/tb_csa_resolve_92.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared carry-save parameters and the redundant {c, s} pair type, used by the
// compressor tree and the carry-propagate resolver.
package csa_pkg;

    localparam int CSA_WIDTH  = 92;
    localparam int CSA_LIMB   = 23;
    localparam int CSA_STAGES = CSA_WIDTH / CSA_LIMB;

    typedef struct packed {
        logic [CSA_WIDTH-1:0] c;
        logic [CSA_WIDTH-1:0] s;
    } csa_pair_t;

endpackage

// File: rtl/cpa_limb.sv
// One LIMB-bit carry-propagate adder slice with carry in/out.
module cpa_limb #(
    parameter int LIMB = 23
) (
    input  logic [LIMB-1:0] a,
    input  logic [LIMB-1:0] b,
    input  logic            cin,
    output logic [LIMB-1:0] sum,
    output logic            cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{LIMB{1'b0}}, cin};

endmodule

// File: rtl/csa_resolve_92.sv
// Pipelined carry-save to binary resolver, one limb per stage, valid/ready with
// a global stall. Optional bit-WIDTH carry and sticky overflow: CSA_RESOLVE_OVF_EN.
module csa_resolve_92
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH,
    parameter int LIMB  = CSA_LIMB
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_c,
    input  logic [WIDTH-1:0] in_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             ovf_sticky
);

    localparam int STAGES = WIDTH / LIMB;
    localparam logic [WIDTH-1:0] LMASK = {{(WIDTH-LIMB){1'b0}}, {LIMB{1'b1}}};

    if (WIDTH % LIMB != 0) begin : g_bad_width
        $error("csa_resolve_92: WIDTH must be a multiple of LIMB");
    end

    // Index 0 is the input capture register; index k holds the result of adder k-1.
    logic                         adv;
    logic [STAGES:0]              vld_pipe;
    logic [STAGES:0][WIDTH-1:0]   s_q;
    logic [STAGES-1:0][WIDTH-1:0] c_q;
    logic [STAGES-1:0][WIDTH-1:0] s_nx;
    logic [STAGES-1:0][LIMB-1:0]  lsum;
    logic [STAGES-1:0]            lcout;
    logic [STAGES-1:0]            cin;
    logic [STAGES-2:0]            cy_q;

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[STAGES];
    assign out_sum   = s_q[STAGES];
    assign cin       = {cy_q, 1'b0};

    for (genvar j = 0; j < STAGES; j++) begin : g_stage
        cpa_limb #(.LIMB(LIMB)) u_limb (
            .a    (c_q[j][j*LIMB +: LIMB]),
            .b    (s_q[j][j*LIMB +: LIMB]),
            .cin  (cin[j]),
            .sum  (lsum[j]),
            .cout (lcout[j])
        );
        // Resolved limb replaces the sum limb in place; other limbs ride along.
        assign s_nx[j] = (s_q[j] & ~(LMASK << (j*LIMB))) | (WIDTH'(lsum[j]) << (j*LIMB));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            s_q      <= '0;
            c_q      <= '0;
            cy_q     <= '0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
            c_q[0]   <= in_c;
            s_q[0]   <= in_s;
            for (int j = 0; j < STAGES; j++) begin
                s_q[j+1] <= s_nx[j];
            end
            for (int j = 0; j < STAGES-1; j++) begin
                c_q[j+1] <= c_q[j];
                cy_q[j]  <= lcout[j];
            end
        end
    end

`ifdef CSA_RESOLVE_OVF_EN
    logic carry_q;
    logic sticky_q;
    logic unused_bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            if (adv) carry_q <= lcout[STAGES-1];
            if (out_valid && out_ready && carry_q) sticky_q <= 1'b1;
        end
    end

    assign out_carry   = carry_q;
    assign ovf_sticky  = sticky_q;
    assign unused_bits = ^c_q[STAGES-1];
`else
    // Top carry is dropped; only the top limb of the last carry vector is consumed.
    logic unused_bits;
    assign out_carry   = 1'b0;
    assign ovf_sticky  = 1'b0;
    assign unused_bits = ^{c_q[STAGES-1], lcout[STAGES-1]};
`endif

endmodule

// File: tb/tb_csa_resolve_92.sv
// Self-checking bench for csa_resolve_92: vector table, latency, stall, bubbles
// and mid-flight reset against a queue-based reference.
module tb_csa_resolve_92;

    localparam int W = 92;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_c;
    logic [W-1:0] in_s;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_carry;
    logic         ovf_sticky;

    csa_resolve_92 dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_c       (in_c),
        .in_s       (in_s),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_carry  (out_carry),
        .ovf_sticky (ovf_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] c;
        logic [W-1:0] s;
        logic [W-1:0] esum;
        logic         ecar;
    } vec_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         car;
    } exp_t;

    int           total = 0;
    int           bad   = 0;
    exp_t         sb[$];
    logic         exp_sticky = 1'b0;
    logic         held = 1'b0;
    logic [W-1:0] held_sum;
    logic         held_car;
    vec_t         tbl[6];

    function automatic logic eff_car(input logic b);
`ifdef CSA_RESOLVE_OVF_EN
        return b;
`else
        return 1'b0 & b;
`endif
    endfunction

    task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // One clock: drive at negedge, check/score, cross the edge, return at negedge.
    task automatic cyc(input logic v, input logic [W-1:0] c, input logic [W-1:0] s,
                       input logic ordy, input logic [W-1:0] esum, input logic ecar,
                       output logic acc);
        exp_t e;
        logic set_st;
        set_st    = 1'b0;
        in_valid  = v;
        in_c      = c;
        in_s      = s;
        out_ready = ordy;
        #1;
        chk("ovf_sticky", {{W{1'b0}}, ovf_sticky}, {{W{1'b0}}, exp_sticky});
        if (held) begin
            chk("stall_sum", {1'b0, out_sum}, {1'b0, held_sum});
            chk("stall_carry", {{W{1'b0}}, out_carry}, {{W{1'b0}}, held_car});
        end
        held     = out_valid && !out_ready;
        held_sum = out_sum;
        held_car = out_carry;
        if (out_valid && !out_ready)
            chk("stall_in_ready", {{W{1'b0}}, in_ready}, '0);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("extra_out_valid", {{W{1'b0}}, out_valid}, '0);
            end else begin
                e = sb.pop_front();
                chk("sum", {1'b0, out_sum}, {1'b0, e.sum});
                chk("carry", {{W{1'b0}}, out_carry}, {{W{1'b0}}, e.car});
                if (e.car) set_st = 1'b1;
            end
        end
        acc = v && in_ready;
        if (acc) begin
            e.sum = esum;
            e.car = eff_car(ecar);
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        if (set_st) exp_sticky = 1'b1;
    endtask

    task automatic cyc_model(input logic v, input logic [W-1:0] c, input logic [W-1:0] s,
                             input logic ordy, output logic acc);
        logic [W:0] m;
        m = {1'b0, c} + {1'b0, s};
        cyc(v, c, s, ordy, m[W-1:0], m[W], acc);
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 40 && sb.size() > 0; i++)
            cyc(1'b0, '0, '0, 1'b1, '0, 1'b0, acc);
        chk("drain_timeout", W'(sb.size()), '0);
    endtask

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] r;
        r = {$urandom, $urandom, $urandom};
        return r;
    endfunction

    initial begin
        logic acc;
        int   n;
        int   it;
        logic [W-1:0] rc[10];
        logic [W-1:0] rs[10];

        tbl[0] = '{92'h0, 92'h5, 92'h5, 1'b0};
        tbl[1] = '{92'h2, 92'h7F_FFFF, 92'h80_0001, 1'b0};
        tbl[2] = '{92'h1, 92'hFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 92'h0, 1'b1};
        tbl[3] = '{92'hFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 92'hFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
                   92'hFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1'b1};
        tbl[4] = '{92'h1, 92'h1F_FFFF_FFFF_FFFF_FFFF, 92'h20_0000_0000_0000_0000, 1'b0};
        tbl[5] = '{92'h800_0000_0000_0000_0000_0000, 92'h800_0000_0000_0000_0000_0000, 92'h0, 1'b1};

        rst = 1'b1; in_valid = 1'b1; in_c = '1; in_s = '1; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_out_valid", {{W{1'b0}}, out_valid}, '0);
        chk("rst_out_sum", {1'b0, out_sum}, '0);
        chk("rst_out_carry", {{W{1'b0}}, out_carry}, '0);
        chk("rst_ovf_sticky", {{W{1'b0}}, ovf_sticky}, '0);
        chk("rst_in_ready", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});

        // Latency: accepted at edge N, out_valid first seen after edge N+4.
        cyc(1'b1, 92'h0, 92'h5, 1'b1, 92'h5, 1'b0, acc);
        chk("lat_accept", {{W{1'b0}}, acc}, {{W{1'b0}}, 1'b1});
        for (int i = 0; i < 4; i++) begin
            chk("lat_early_valid", {{W{1'b0}}, out_valid}, '0);
            cyc(1'b0, '0, '0, 1'b1, '0, 1'b0, acc);
        end
        chk("lat_valid", {{W{1'b0}}, out_valid}, {{W{1'b0}}, 1'b1});
        chk("lat_sum", {1'b0, out_sum}, 93'h5);
        drain();

        for (int i = 0; i < 6; i++)
            cyc(1'b1, tbl[i].c, tbl[i].s, 1'b1, tbl[i].esum, tbl[i].ecar, acc);
        drain();

        // Backpressure: 10 back-to-back pairs with a 5-cycle consumer stall.
        for (int i = 0; i < 10; i++) begin
            rc[i] = rnd();
            rs[i] = rnd();
        end
        n  = 0;
        it = 0;
        while (n < 10 && it < 60) begin
            cyc_model(1'b1, rc[n], rs[n], !(it >= 4 && it < 9), acc);
            if (acc) n++;
            it++;
        end
        chk("bp_accepted", W'(n), W'(10));
        drain();

        // Bubbles with random consumer readiness.
        for (int i = 0; i < 40; i++)
            cyc_model(i % 2 == 0, rnd(), rnd(), 1'($urandom_range(0, 1)), acc);
        drain();

        // Reset mid-flight: three in-flight results must never appear.
        for (int i = 0; i < 3; i++)
            cyc_model(1'b1, rnd(), rnd(), 1'b1, acc);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        exp_sticky = 1'b0;
        held = 1'b0;
        #1;
        chk("midrst_out_valid", {{W{1'b0}}, out_valid}, '0);
        chk("midrst_out_sum", {1'b0, out_sum}, '0);
        for (int i = 0; i < 8; i++)
            cyc(1'b0, '0, '0, 1'b1, '0, 1'b0, acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
